// File: rtl/imm_extend_pipe.sv
// Registered IN_W->OUT_W immediate extender (sign/zero/shifted/upper) behind a valid/ready stage with a one-entry skid buffer.
// Optional overflow flag for the shifted mode is enabled by defining IMMEXT_OVF_EN.
module imm_extend_pipe #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 16,
    parameter int SHIFT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_imm
`ifdef IMMEXT_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    typedef enum logic [1:0] {
        MODE_SEXT  = 2'd0,
        MODE_ZEXT  = 2'd1,
        MODE_SHL   = 2'd2,
        MODE_UPPER = 2'd3
    } mode_e;

    logic [OUT_W-1:0] w_sext;
    logic [OUT_W-1:0] w_zext;
    logic [OUT_W-1:0] w_shl;
    logic [OUT_W-1:0] w_upper;
    logic [OUT_W-1:0] w_ext;
    logic             w_in_fire;
    logic             w_main_free;

    logic             r_out_valid;
    logic [OUT_W-1:0] r_out_imm;
    logic             r_skid_valid;
    logic [OUT_W-1:0] r_skid_imm;

    assign w_sext  = OUT_W'($signed(in_imm));
    assign w_zext  = OUT_W'(in_imm);
    assign w_shl   = w_sext << SHIFT;
    assign w_upper = OUT_W'(in_imm) << (OUT_W - IN_W);

    always_comb begin
        w_ext = w_sext;
        case (mode_e'(in_mode))
            MODE_SEXT:  w_ext = w_sext;
            MODE_ZEXT:  w_ext = w_zext;
            MODE_SHL:   w_ext = w_shl;
            MODE_UPPER: w_ext = w_upper;
            default:    w_ext = w_sext;
        endcase
    end

`ifdef IMMEXT_OVF_EN
    logic w_ovf;
    logic r_out_ovf;
    logic r_skid_ovf;

    // The shifted value fits only if every bit pushed off the top matches the new sign bit.
    always_comb begin
        w_ovf = 1'b0;
        if (mode_e'(in_mode) == MODE_SHL) begin
            for (int i = 0; i < SHIFT; i++) begin
                if (w_sext[OUT_W-1-i] != w_shl[OUT_W-1])
                    w_ovf = 1'b1;
            end
        end
    end

    assign out_ovf = r_out_ovf;
`endif

    assign in_ready    = !r_skid_valid;
    assign w_in_fire   = in_valid && !r_skid_valid;
    assign w_main_free = !r_out_valid || out_ready;

    // Main refills from skid first to keep FIFO order; skid only fills while main is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_imm    <= '0;
            r_skid_valid <= 1'b0;
            r_skid_imm   <= '0;
`ifdef IMMEXT_OVF_EN
            r_out_ovf    <= 1'b0;
            r_skid_ovf   <= 1'b0;
`endif
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_out_imm    <= r_skid_imm;
                r_skid_valid <= 1'b0;
`ifdef IMMEXT_OVF_EN
                r_out_ovf    <= r_skid_ovf;
`endif
            end else begin
                r_out_valid <= w_in_fire;
                if (w_in_fire) begin
                    r_out_imm <= w_ext;
`ifdef IMMEXT_OVF_EN
                    r_out_ovf <= w_ovf;
`endif
                end
            end
        end else if (w_in_fire) begin
            r_skid_valid <= 1'b1;
            r_skid_imm   <= w_ext;
`ifdef IMMEXT_OVF_EN
            r_skid_ovf   <= w_ovf;
`endif
        end
    end

    assign out_valid = r_out_valid;
    assign out_imm   = r_out_imm;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: default 12/16/1 instance, a SHIFT=5 instance and a 16/16 edge instance.
// Overflow checks are compiled in when IMMEXT_OVF_EN is defined.
module tb_imm_extend_pipe;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // Default-parameter instance
    logic        inValid, inReady, outValid, outReady;
    logic [11:0] inImm;
    logic [1:0]  inMode;
    logic [15:0] outImm;
    logic        outOvf;

    // SHIFT = 5 instance
    logic        s5InValid, s5InReady, s5OutValid, s5OutReady;
    logic [11:0] s5InImm;
    logic [1:0]  s5InMode;
    logic [15:0] s5OutImm;
    logic        s5OutOvf;

    // IN_W = OUT_W = 16 instance
    logic        wInValid, wInReady, wOutValid, wOutReady;
    logic [15:0] wInImm;
    logic [1:0]  wInMode;
    logic [15:0] wOutImm;
    logic        wOutOvf;

    imm_extend_pipe #(.IN_W(12), .OUT_W(16), .SHIFT(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(inValid), .in_ready(inReady), .in_imm(inImm), .in_mode(inMode),
        .out_valid(outValid), .out_ready(outReady), .out_imm(outImm)
`ifdef IMMEXT_OVF_EN
        , .out_ovf(outOvf)
`endif
    );

    imm_extend_pipe #(.IN_W(12), .OUT_W(16), .SHIFT(5)) dutS5 (
        .clk(clk), .rst(rst),
        .in_valid(s5InValid), .in_ready(s5InReady), .in_imm(s5InImm), .in_mode(s5InMode),
        .out_valid(s5OutValid), .out_ready(s5OutReady), .out_imm(s5OutImm)
`ifdef IMMEXT_OVF_EN
        , .out_ovf(s5OutOvf)
`endif
    );

    imm_extend_pipe #(.IN_W(16), .OUT_W(16), .SHIFT(1)) dutW (
        .clk(clk), .rst(rst),
        .in_valid(wInValid), .in_ready(wInReady), .in_imm(wInImm), .in_mode(wInMode),
        .out_valid(wOutValid), .out_ready(wOutReady), .out_imm(wOutImm)
`ifdef IMMEXT_OVF_EN
        , .out_ovf(wOutOvf)
`endif
    );

`ifndef IMMEXT_OVF_EN
    assign outOvf   = 1'b0;
    assign s5OutOvf = 1'b0;
    assign wOutOvf  = 1'b0;
`endif

    typedef struct {
        logic [11:0] imm;
        logic [1:0]  mode;
        logic [15:0] expImm;
    } vec_t;

    vec_t vecs[8];
    int   nCompared   = 0;
    int   nMismatched = 0;

    // Reference model for the default 12->16, SHIFT=1 configuration
    function automatic logic [15:0] model(input logic [11:0] imm, input logic [1:0] mode);
        logic [15:0] s;
        s = {4'b0000, imm};
        if (imm[11]) s = s | 16'hF000;
        case (mode)
            2'd0:    return s;
            2'd1:    return {4'b0000, imm};
            2'd2:    return {s[14:0], 1'b0};
            default: return {imm, 4'b0000};
        endcase
    endfunction

    // Advance one clock and settle just past the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [11:0] imm, input logic [1:0] mode);
        inValid = v;
        inImm   = imm;
        inMode  = mode;
    endtask

    initial begin
        vecs[0] = '{12'h800, 2'd0, 16'hF800};
        vecs[1] = '{12'h800, 2'd1, 16'h0800};
        vecs[2] = '{12'h7FF, 2'd2, 16'h0FFE};
        vecs[3] = '{12'hABC, 2'd3, 16'hABC0};
        vecs[4] = '{12'h7FF, 2'd0, 16'h07FF};
        vecs[5] = '{12'hFFF, 2'd1, 16'h0FFF};
        vecs[6] = '{12'h800, 2'd2, 16'hF000};
        vecs[7] = '{12'h001, 2'd3, 16'h0010};

        rst = 1'b1;
        applyStimulus(1'b1, 12'h555, 2'd0);
        outReady   = 1'b1;
        s5InValid  = 1'b0; s5InImm = '0; s5InMode = 2'd2; s5OutReady = 1'b1;
        wInValid   = 1'b0; wInImm  = '0; wInMode  = 2'd3; wOutReady  = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 12'h000, 2'd0);
        checkOutput("reset_out_valid", 32'(outValid), 32'd0);
        checkOutput("reset_out_imm", 32'(outImm), 32'd0);
        checkOutput("reset_in_ready", 32'(inReady), 32'd1);
        checkOutput("reset_ovf", 32'(outOvf), 32'd0);

        // Single transfers with one-cycle latency
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, vecs[i].imm, vecs[i].mode);
            checkOutput($sformatf("vec%0d_in_ready", i), 32'(inReady), 32'd1);
            tick();
            applyStimulus(1'b0, 12'h000, 2'd0);
            checkOutput($sformatf("vec%0d_valid", i), 32'(outValid), 32'd1);
            checkOutput($sformatf("vec%0d_imm", i), 32'(outImm), 32'(vecs[i].expImm));
            checkOutput($sformatf("vec%0d_ovf", i), 32'(outOvf), 32'd0);
            tick();
            checkOutput($sformatf("vec%0d_drained", i), 32'(outValid), 32'd0);
        end

        // Stall: two entries fill main and skid, the third is held off
        outReady = 1'b0;
        applyStimulus(1'b1, 12'h001, 2'd0);
        tick();
        checkOutput("stall_first_valid", 32'(outValid), 32'd1);
        checkOutput("stall_ready_after_1", 32'(inReady), 32'd1);
        applyStimulus(1'b1, 12'h002, 2'd0);
        tick();
        checkOutput("stall_ready_after_2", 32'(inReady), 32'd0);
        checkOutput("stall_hold_imm", 32'(outImm), 32'h0001);
        applyStimulus(1'b1, 12'h003, 2'd0);
        tick();
        checkOutput("stall_still_blocked", 32'(inReady), 32'd0);
        checkOutput("stall_stable_imm", 32'(outImm), 32'h0001);
        checkOutput("stall_stable_valid", 32'(outValid), 32'd1);
        outReady = 1'b1;
        tick();
        checkOutput("drain_out2", 32'(outImm), 32'h0002);
        checkOutput("drain_valid2", 32'(outValid), 32'd1);
        checkOutput("drain_ready_back", 32'(inReady), 32'd1);
        tick();
        applyStimulus(1'b0, 12'h000, 2'd0);
        checkOutput("drain_out3", 32'(outImm), 32'h0003);
        checkOutput("drain_valid3", 32'(outValid), 32'd1);
        tick();
        checkOutput("drain_empty", 32'(outValid), 32'd0);

        // Back-to-back streaming
        for (int i = 0; i < 16; i++) begin
            logic [11:0] imm;
            logic [1:0]  mode;
            imm  = 12'(i * 12'h111 + 12'h80F * (i % 3));
            mode = 2'(i % 4);
            applyStimulus(1'b1, imm, mode);
            checkOutput($sformatf("stream%0d_in_ready", i), 32'(inReady), 32'd1);
            tick();
            checkOutput($sformatf("stream%0d_valid", i), 32'(outValid), 32'd1);
            checkOutput($sformatf("stream%0d_imm", i), 32'(outImm), 32'(model(imm, mode)));
        end
        applyStimulus(1'b0, 12'h000, 2'd0);
        tick();
        checkOutput("stream_end_empty", 32'(outValid), 32'd0);

        // Reset while two entries are stalled; nothing stale may come out afterwards
        outReady = 1'b0;
        applyStimulus(1'b1, 12'h0AA, 2'd1);
        tick();
        applyStimulus(1'b1, 12'h0BB, 2'd1);
        tick();
        checkOutput("prerst_ready_low", 32'(inReady), 32'd0);
        rst = 1'b1;
        applyStimulus(1'b1, 12'hCCC, 2'd1);
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 12'h000, 2'd0);
        checkOutput("midrst_out_valid", 32'(outValid), 32'd0);
        checkOutput("midrst_out_imm", 32'(outImm), 32'd0);
        checkOutput("midrst_in_ready", 32'(inReady), 32'd1);
        outReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("postrst_no_stale%0d", i), 32'(outValid), 32'd0);
        end
        applyStimulus(1'b1, 12'h123, 2'd1);
        tick();
        applyStimulus(1'b0, 12'h000, 2'd0);
        checkOutput("postrst_fresh", 32'(outImm), 32'h0123);

        // SHIFT = 5, mode 2 (overflow flag when compiled in)
        s5InValid = 1'b1; s5InImm = 12'h400;
        tick();
        checkOutput("s5_400_imm", 32'(s5OutImm), 32'h8000);
`ifdef IMMEXT_OVF_EN
        checkOutput("s5_400_ovf", 32'(s5OutOvf), 32'd1);
`endif
        s5InImm = 12'hFFF;
        tick();
        checkOutput("s5_FFF_imm", 32'(s5OutImm), 32'hFFE0);
`ifdef IMMEXT_OVF_EN
        checkOutput("s5_FFF_ovf", 32'(s5OutOvf), 32'd0);
`endif
        s5InImm = 12'h200;
        tick();
        checkOutput("s5_200_imm", 32'(s5OutImm), 32'h4000);
`ifdef IMMEXT_OVF_EN
        checkOutput("s5_200_ovf", 32'(s5OutOvf), 32'd0);
`endif
        s5InImm = 12'h400; s5InMode = 2'd0;
        tick();
        s5InValid = 1'b0;
        checkOutput("s5_mode0_imm", 32'(s5OutImm), 32'h0400);
`ifdef IMMEXT_OVF_EN
        checkOutput("s5_mode0_ovf", 32'(s5OutOvf), 32'd0);
`endif

        // IN_W == OUT_W edge case
        wInValid = 1'b1; wInImm = 16'h8001; wInMode = 2'd3;
        tick();
        checkOutput("w16_mode3", 32'(wOutImm), 32'h8001);
        wInMode = 2'd0;
        tick();
        checkOutput("w16_mode0", 32'(wOutImm), 32'h8001);
        wInMode = 2'd1;
        tick();
        checkOutput("w16_mode1", 32'(wOutImm), 32'h8001);
        wInMode = 2'd2;
        tick();
        wInValid = 1'b0;
        checkOutput("w16_mode2", 32'(wOutImm), 32'h0002);
        checkOutput("w16_valid", 32'(wOutValid), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
